multicycle_controller: RTL and testbench

Main control FSM for the RISC-V multi-cycle core. Sequences one shared ALU, the instruction/data memory port, the instruction register, PC and register file through fetch, decode, execute, memory and writeback. Emits datapath mux selects and write enables. ALU operation selection stays in the ALU decoder; this block only forces "add" when the datapath needs address or PC arithmetic.

---
 rtl/riscv_pkg.sv | 61 ++++++
 rtl/imm_src_decoder.sv | 26 ++
 rtl/multicycle_controller.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the multi-cycle RISC-V control path:
//   - state_t     : main control FSM states (4 bits, 14 states)
//   - OP_*        : 7-bit major opcodes understood by the controller
//   - IMM_*       : ImmSrc encodings for the immediate extender
//   - RES_*       : ResultSrc encodings for the result bus mux
//   - SRCA_*/SRCB_*: ALU operand mux encodings
//   - opIsLegal() : true for the opcodes DECODE knows how to dispatch
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_LUI      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JALR     = 4'd12,
    S_JALLINK  = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic opIsLegal(input logic [6:0] op);
    return (op == OP_LOAD)   || (op == OP_STORE) || (op == OP_RTYPE) ||
           (op == OP_ITYPE)  || (op == OP_BRANCH) || (op == OP_JAL) ||
           (op == OP_JALR)   || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/imm_src_decoder.sv
// imm_src_decoder
// Combinational opcode -> immediate format map, shared between the
// controller and the immediate extender.
// Ports:
//   opcode_i [6:0] : opcode field of the instruction register
//   immSrc_o [2:0] : immediate format (IMM_I/S/B/J/U); unknown opcodes give IMM_I
module imm_src_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic [2:0] immSrc_o
);

  // R-type carries no immediate; it falls through to the I-format default.
  always_comb begin
    immSrc_o = IMM_I;
    unique case (opcode_i)
      OP_STORE:  immSrc_o = IMM_S;
      OP_BRANCH: immSrc_o = IMM_B;
      OP_JAL:    immSrc_o = IMM_J;
      OP_LUI:    immSrc_o = IMM_U;
      default:   immSrc_o = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Main control FSM of the multi-cycle RISC-V core. Steps the shared ALU,
// memory port, IR, PC and register file through fetch/decode/execute/
// memory/writeback and drives the datapath selects and write enables.
// Ports:
//   clk, rst            : rising-edge clock, async active-high reset
//   op [6:0]            : opcode from the IR
//   cond                : ALU compare result (branch taken)
//   mem_ready           : memory access completes this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite : datapath strobes/selects
//   ResultSrc, ALUSrcA, ALUSrcB [1:0]            : datapath mux selects
//   ImmSrc [2:0]        : immediate format for the extender
//   ALUAdd              : force the ALU to add (address/PC arithmetic)
//   bus_err             : one-cycle pulse when a memory wait times out
//   illegal_op          : one-cycle pulse on an unknown opcode in DECODE
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       cond,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic       ALUAdd,
  output logic       bus_err,
  output logic       illegal_op
);

  // At least one bit so a disabled timeout still elaborates cleanly.
  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   waitCnt_q, waitCnt_d;
  logic               waitState;
  logic               timeoutHit;
  logic               pcWriteRaw, irWriteRaw, memWriteRaw, regWriteRaw;
  logic               illegalRaw;

  imm_src_decoder uImmSrc (
    .opcode_i (op),
    .immSrc_o (ImmSrc)
  );

  // States that can stall on the memory port.
  assign waitState = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                     (state_q == S_MEMWRITE);

  // mem_ready in the timeout cycle wins, hence the !mem_ready term.
  assign timeoutHit = (MEM_TIMEOUT > 0) && waitState && !mem_ready &&
                      (32'(waitCnt_q) == 32'(MEM_TIMEOUT - 1));

  // Next state. A timeout always returns to FETCH so the same PC is re-fetched
  // (PC was not written during the failed fetch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready)       state_d = S_DECODE;
        else if (timeoutHit) state_d = S_FETCH;
      end
      S_DECODE: begin
        unique case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_ready)       state_d = S_MEMWB;
        else if (timeoutHit) state_d = S_FETCH;
      end
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready || timeoutHit) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI, S_LUI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JALLINK;
      S_JALLINK:  state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Stall counter: increments only while stuck in a wait state, saturating at
  // all-ones. Any state change (including the timeout back to FETCH) clears it.
  always_comb begin
    waitCnt_d = '0;
    if (waitState && !mem_ready && !timeoutHit) begin
      waitCnt_d = (waitCnt_q == '1) ? waitCnt_q : waitCnt_q + 1'b1;
    end
  end

  // State and stall counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // Moore decode of the datapath controls. Kept combinational because the
  // fetch strobes must follow mem_ready in the same cycle.
  always_comb begin
    pcWriteRaw  = 1'b0;
    irWriteRaw  = 1'b0;
    memWriteRaw = 1'b0;
    regWriteRaw = 1'b0;
    illegalRaw  = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;
    ALUAdd      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_FOUR;
        ALUAdd     = 1'b1;
        ResultSrc  = RES_ALURESULT;
        pcWriteRaw = mem_ready;
        irWriteRaw = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_IMM;
        ALUAdd     = 1'b1;
        illegalRaw = !opIsLegal(op);
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUAdd  = 1'b1;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc   = RES_MEMDATA;
        regWriteRaw = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        memWriteRaw = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_LUI: ALUSrcB = SRCB_IMM;
      S_ALUWB: begin
        ResultSrc   = RES_ALUOUT;
        regWriteRaw = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ResultSrc  = RES_ALUOUT;
        pcWriteRaw = cond;
      end
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        ALUAdd     = 1'b1;
        ResultSrc  = RES_ALUOUT;
        pcWriteRaw = 1'b1;
      end
      S_JALR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ALUAdd     = 1'b1;
        ResultSrc  = RES_ALURESULT;
        pcWriteRaw = 1'b1;
      end
      S_JALLINK: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        ALUAdd  = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset masks every write so an aborted instruction leaves no partial update.
  // A timeout only ever occurs in wait states where PC/IR/Reg writes are
  // already low, while MemWrite stays asserted through it.
  assign PCWrite    = pcWriteRaw  && !rst;
  assign IRWrite    = irWriteRaw  && !rst;
  assign MemWrite   = memWriteRaw && !rst;
  assign RegWrite   = regWriteRaw && !rst;
  assign bus_err    = timeoutHit  && !rst;
  assign illegal_op = illegalRaw  && !rst;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
// Directed bench for the multi-cycle control FSM. Each step drives inputs at
// the falling edge, waits 1 time unit and compares the whole control word
// against a hand-written expected word.
// Word layout: {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
//               ALUSrcA, ALUSrcB, ImmSrc, ALUAdd, bus_err, illegal_op}
module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic       cond;
  logic       memReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic       ALUAdd, busErr, illegalOp;
  logic [16:0] observed;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BAD    = 7'b1111111;

  multicycle_controller #(.MEM_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .cond       (cond),
    .mem_ready  (memReady),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUAdd     (ALUAdd),
    .bus_err    (busErr),
    .illegal_op (illegalOp)
  );

  assign observed = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                     ALUSrcA, ALUSrcB, ImmSrc, ALUAdd, busErr, illegalOp};

  // 10-unit clock; rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs the expected control fields in the same order as 'observed'.
  function automatic logic [16:0] w(input logic pc, adr, mw, ir, rw,
                                    input logic [1:0] rs, sa, sb,
                                    input logic [2:0] imm,
                                    input logic add, be, il);
    return {pc, adr, mw, ir, rw, rs, sa, sb, imm, add, be, il};
  endfunction

  // Drives one cycle's inputs at the falling edge and lets outputs settle.
  task automatic applyStimulus(input logic rstv, input logic [6:0] opv,
                               input logic condv, input logic rdyv);
    @(negedge clk);
    rst      = rstv;
    op       = opv;
    cond     = condv;
    memReady = rdyv;
    #1;
  endtask

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [16:0] got,
                             input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Directed instruction sequences with hand-derived control words.
  initial begin
    rst = 1'b1; op = OPC_R; cond = 1'b0; memReady = 1'b1;

    // Reset: FETCH controls visible but every write forced low.
    applyStimulus(1, OPC_R, 0, 1);
    checkOutput("reset", observed, w(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,1,0,0));

    // R-type, zero wait states.
    applyStimulus(0, OPC_R, 0, 1);
    checkOutput("r_fetch",  observed, w(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,1,0,0));
    applyStimulus(0, OPC_R, 0, 1);
    checkOutput("r_decode", observed, w(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,1,0,0));
    applyStimulus(0, OPC_R, 0, 1);
    checkOutput("r_execr",  observed, w(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,0,0,0));
    applyStimulus(0, OPC_R, 0, 1);
    checkOutput("r_aluwb",  observed, w(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,0,0,0));

    // Load with three stalls; the fourth MEMREAD cycle is the timeout
    // boundary but mem_ready arrives, so no bus_err.
    applyStimulus(0, OPC_LOAD, 0, 1);
    checkOutput("ld_fetch",  observed, w(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,1,0,0));
    applyStimulus(0, OPC_LOAD, 0, 1);
    checkOutput("ld_decode", observed, w(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,1,0,0));
    applyStimulus(0, OPC_LOAD, 0, 1);
    checkOutput("ld_memadr", observed, w(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,1,0,0));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, OPC_LOAD, 0, 0);
      checkOutput($sformatf("ld_memread_stall%0d", i), observed,
                  w(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0,0));
    end
    applyStimulus(0, OPC_LOAD, 0, 1);
    checkOutput("ld_memread_done", observed, w(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0,0));
    applyStimulus(0, OPC_LOAD, 0, 1);
    checkOutput("ld_memwb", observed, w(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,0,0,0));

    // Branch taken then not taken.
    for (int t = 1; t >= 0; t--) begin
      applyStimulus(0, OPC_BRANCH, 0, 1);
      checkOutput("br_fetch",  observed, w(1,0,0,1,0,2'b10,2'b00,2'b10,3'b010,1,0,0));
      applyStimulus(0, OPC_BRANCH, 0, 1);
      checkOutput("br_decode", observed, w(0,0,0,0,0,2'b00,2'b01,2'b01,3'b010,1,0,0));
      applyStimulus(0, OPC_BRANCH, logic'(t), 1);
      checkOutput($sformatf("br_branch_cond%0d", t), observed,
                  w(logic'(t),0,0,0,0,2'b00,2'b10,2'b00,3'b010,0,0,0));
    end

    // JALR: PC written in JALR, link written after JALLINK.
    applyStimulus(0, OPC_JALR, 0, 1);
    checkOutput("jalr_fetch",   observed, w(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,1,0,0));
    applyStimulus(0, OPC_JALR, 0, 1);
    checkOutput("jalr_decode",  observed, w(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,1,0,0));
    applyStimulus(0, OPC_JALR, 0, 1);
    checkOutput("jalr_jalr",    observed, w(1,0,0,0,0,2'b10,2'b10,2'b01,3'b000,1,0,0));
    applyStimulus(0, OPC_JALR, 0, 1);
    checkOutput("jalr_jallink", observed, w(0,0,0,0,0,2'b00,2'b01,2'b10,3'b000,1,0,0));
    applyStimulus(0, OPC_JALR, 0, 1);
    checkOutput("jalr_aluwb",   observed, w(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,0,0,0));

    // JAL (J-format immediate).
    applyStimulus(0, OPC_JAL, 0, 1);
    checkOutput("jal_fetch",  observed, w(1,0,0,1,0,2'b10,2'b00,2'b10,3'b011,1,0,0));
    applyStimulus(0, OPC_JAL, 0, 1);
    checkOutput("jal_decode", observed, w(0,0,0,0,0,2'b00,2'b01,2'b01,3'b011,1,0,0));
    applyStimulus(0, OPC_JAL, 0, 1);
    checkOutput("jal_jal",    observed, w(1,0,0,0,0,2'b00,2'b01,2'b10,3'b011,1,0,0));
    applyStimulus(0, OPC_JAL, 0, 1);
    checkOutput("jal_aluwb",  observed, w(0,0,0,0,1,2'b00,2'b00,2'b00,3'b011,0,0,0));

    // Fetch timeout twice in a row: bus_err on the 4th stalled cycle each
    // time, which only repeats if the counter really cleared.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        applyStimulus(0, OPC_BAD, 0, 0);
        checkOutput($sformatf("to_fetch_r%0d_c%0d", r, i), observed,
                    w(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,1,(i == 3),0));
      end
    end

    // Illegal opcode after the fetch finally completes.
    applyStimulus(0, OPC_BAD, 0, 1);
    checkOutput("ill_fetch",  observed, w(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,1,0,0));
    applyStimulus(0, OPC_BAD, 0, 1);
    checkOutput("ill_decode", observed, w(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,1,0,1));
    applyStimulus(0, OPC_BAD, 0, 0);
    checkOutput("ill_refetch", observed, w(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,1,0,0));

    // Store, then reset in the middle of MEMWRITE.
    applyStimulus(0, OPC_STORE, 0, 1);
    checkOutput("st_fetch",    observed, w(1,0,0,1,0,2'b10,2'b00,2'b10,3'b001,1,0,0));
    applyStimulus(0, OPC_STORE, 0, 1);
    checkOutput("st_decode",   observed, w(0,0,0,0,0,2'b00,2'b01,2'b01,3'b001,1,0,0));
    applyStimulus(0, OPC_STORE, 0, 1);
    checkOutput("st_memadr",   observed, w(0,0,0,0,0,2'b00,2'b10,2'b01,3'b001,1,0,0));
    applyStimulus(0, OPC_STORE, 0, 0);
    checkOutput("st_memwrite", observed, w(0,1,1,0,0,2'b00,2'b00,2'b00,3'b001,0,0,0));
    applyStimulus(1, OPC_STORE, 0, 0);
    checkOutput("st_reset_abort", observed, w(0,0,0,0,0,2'b10,2'b00,2'b10,3'b001,1,0,0));
    applyStimulus(0, OPC_STORE, 0, 1);
    checkOutput("st_restart_fetch", observed, w(1,0,0,1,0,2'b10,2'b00,2'b10,3'b001,1,0,0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
